// File: rtl/stall_unit_pkg.sv
// Shared pipeline definitions: bubble encodings, load-latency range and the
// stall-unit control vectors for each hazard mode.
package stall_unit_pkg;

    localparam int LOAD_LAT_MIN = 1;
    localparam int LOAD_LAT_MAX = 4;

    // A bubble carries no register write; its pending-load entry is never valid.
    localparam logic BUBBLE_VLD = 1'b0;
    localparam int   NOP_RD     = 0;

    typedef enum logic [1:0] {
        CTL_RUN,
        CTL_LOAD_USE,
        CTL_FLUSH,
        CTL_FREEZE
    } ctl_mode_e;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_write;
        logic hazard;
    } ctl_t;

    localparam ctl_t CTL_RUN_V      = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    localparam ctl_t CTL_LOAD_USE_V = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    localparam ctl_t CTL_FLUSH_V    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    localparam ctl_t CTL_FREEZE_V   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    function automatic ctl_t ctl_for(input ctl_mode_e mode);
        ctl_t c;
        case (mode)
            CTL_FREEZE:   c = CTL_FREEZE_V;
            CTL_FLUSH:    c = CTL_FLUSH_V;
            CTL_LOAD_USE: c = CTL_LOAD_USE_V;
            default:      c = CTL_RUN_V;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/stall_unit_load_scoreboard.sv
// Tracks loads that have left EX but whose data is not yet forwardable, and
// flags which ID sources depend on any load still in flight.
module load_scoreboard
    import stall_unit_pkg::*;
#(
    parameter int NUM_SRC  = 2,
    parameter int AW       = 5,
    parameter int LOAD_LAT = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_SRC*AW-1:0]  id_rs,
    input  logic [NUM_SRC-1:0]     id_rs_used,
    input  logic [AW-1:0]          ex_rd,
    input  logic                   ex_mem_read,
    input  logic                   advance,
    output logic [NUM_SRC-1:0]     match
);

    localparam int DEPTH = LOAD_LAT - 1;
    // With LOAD_LAT=1 one slot still exists but can never become valid.
    localparam int SLOTS = (DEPTH > 0) ? DEPTH : 1;

    logic [SLOTS-1:0] pend_vld_p;
    logic [AW-1:0]    pend_rd_p [SLOTS];
    logic             ex_load_ok;

    assign ex_load_ok = (DEPTH > 0) && ex_mem_read && (ex_rd != AW'(NOP_RD));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_vld_p <= {SLOTS{BUBBLE_VLD}};
        end else if (advance) begin
            pend_vld_p[0] <= ex_load_ok ? 1'b1 : BUBBLE_VLD;
            for (int k = 1; k < SLOTS; k++) begin
                pend_vld_p[k] <= pend_vld_p[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (advance) begin
            pend_rd_p[0] <= ex_rd;
            for (int k = 1; k < SLOTS; k++) begin
                pend_rd_p[k] <= pend_rd_p[k-1];
            end
        end
    end

    // Register zero is hard-wired, so it never carries a dependency.
    always_comb begin
        match = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (id_rs_used[i] && (id_rs[i*AW +: AW] != AW'(NOP_RD))) begin
                if (ex_mem_read && (id_rs[i*AW +: AW] == ex_rd)) begin
                    match[i] = 1'b1;
                end
                for (int k = 0; k < SLOTS; k++) begin
                    if (pend_vld_p[k] && (pend_rd_p[k] == id_rs[i*AW +: AW])) begin
                        match[i] = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/stall_unit.sv
// Pipeline hazard control: freezes on memory stalls, squashes wrong-path
// fetches on taken branches, and inserts bubbles for load-use dependencies.
module stall_unit
    import stall_unit_pkg::*;
#(
    parameter int NUM_SRC  = 2,
    parameter int AW       = 5,
    parameter int LOAD_LAT = 1,
    parameter int CW       = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_SRC*AW-1:0] id_rs,
    input  logic [NUM_SRC-1:0]    id_rs_used,
    input  logic [AW-1:0]         ex_rd,
    input  logic                  ex_mem_read,
    input  logic                  mem_stall,
    input  logic                  ex_flush,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  if_id_flush,
    output logic                  id_ex_write,
    output logic                  hazard_out,
    output logic [CW-1:0]         stall_count
);

    if (LOAD_LAT < LOAD_LAT_MIN || LOAD_LAT > LOAD_LAT_MAX) begin : g_bad_load_lat
        $error("stall_unit: LOAD_LAT out of range");
    end

    logic [NUM_SRC-1:0] src_match;
    logic               advance;
    logic               load_use;
    ctl_mode_e          mode;
    ctl_t               ctl;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + {{(CW-1){1'b0}}, 1'b1};
    endfunction

    assign advance = ~mem_stall;

    load_scoreboard #(
        .NUM_SRC  (NUM_SRC),
        .AW       (AW),
        .LOAD_LAT (LOAD_LAT)
    ) u_load_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .id_rs       (id_rs),
        .id_rs_used  (id_rs_used),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .advance     (advance),
        .match       (src_match)
    );

    assign load_use = |src_match;

    always_comb begin
        mode = CTL_RUN;
        if (mem_stall) begin
            mode = CTL_FREEZE;
        end else if (ex_flush) begin
            mode = CTL_FLUSH;
        end else if (load_use) begin
            mode = CTL_LOAD_USE;
        end
    end

    assign ctl         = ctl_for(mode);
    assign pc_write    = ctl.pc_write;
    assign if_id_write = ctl.if_id_write;
    assign if_id_flush = ctl.if_id_flush;
    assign id_ex_write = ctl.id_ex_write;
    assign hazard_out  = ctl.hazard;

    // A flush bubble also raises hazard_out but is not a load-use stall.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_count <= '0;
        end else if (mode == CTL_LOAD_USE) begin
            stall_count <= sat_inc(stall_count);
        end
    end

endmodule

// File: doc/stall_unit.md
STALL_UNIT -- requirements
Module: stall_unit

Interface
REQ-001 SHALL have parameter NUM_SRC, default 2: number of ID-stage register source ports checked.
REQ-002 SHALL have parameter AW, default 5: register address width.
REQ-003 SHALL have parameter LOAD_LAT, default 1: cycles after EX before load data is forwardable; legal range 1..4.
REQ-004 SHALL have parameter CW, default 16: stall counter width.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port id_rs  input  NUM_SRC*AW  ID source addresses; port i at bits [i*AW +: AW].
REQ-008 SHALL have port id_rs_used  input  NUM_SRC  per-source valid; an unused source never causes a hazard.
REQ-009 SHALL have port ex_rd  input  AW  destination of the instruction in EX.
REQ-010 SHALL have port ex_mem_read  input  1  EX instruction is a load.
REQ-011 SHALL have port mem_stall  input  1  data memory not ready; whole pipeline freezes.
REQ-012 SHALL have port ex_flush  input  1  taken branch/jump resolved in EX; IF and ID hold wrong-path instructions.
REQ-013 SHALL have port pc_write  output  1  PC update enable.
REQ-014 SHALL have port if_id_write  output  1  IF/ID register enable.
REQ-015 SHALL have port if_id_flush  output  1  clear IF/ID to NOP.
REQ-016 SHALL have port id_ex_write  output  1  ID/EX register enable.
REQ-017 SHALL have port hazard_out  output  1  load-use stall: ID/EX control zeroed (bubble).
REQ-018 SHALL have port stall_count  output  CW  saturating count of load-use stall cycles.

Function
REQ-019 SHALL keep a pending-load pipe of LOAD_LAT-1 entries {valid, rd}; entry 1 loads from EX, entry k loads from entry k-1.
REQ-020 SHALL advance the pending pipe every cycle mem_stall=0; hold it when mem_stall=1.
REQ-021 SHALL load entry 1 with valid=ex_mem_read && ex_rd!=0 and rd=ex_rd on advance; a bubble in EX loads valid=0.
REQ-022 SHALL detect a load-use match for source i when id_rs_used[i]=1, rs_i!=0, and rs_i equals ex_rd with ex_mem_read=1 or equals rd of any valid pending entry.
REQ-023 SHALL be purely combinational from inputs and pending pipe to control outputs (zero latency).
REQ-024 SHALL apply priority mem_stall > ex_flush > load-use.
REQ-025 SHALL, when mem_stall=1: pc_write=0, if_id_write=0, id_ex_write=0, if_id_flush=0, hazard_out=0.
REQ-026 SHALL, when ex_flush=1 and mem_stall=0: pc_write=1, if_id_write=1, if_id_flush=1, id_ex_write=1, hazard_out=1 (bubble replaces wrong-path ID instruction); no load-use stall counted.
REQ-027 SHALL, on load-use match with no higher-priority event: pc_write=0, if_id_write=0, id_ex_write=1, hazard_out=1, if_id_flush=0.
REQ-028 SHALL otherwise drive pc_write=1, if_id_write=1, id_ex_write=1, if_id_flush=0, hazard_out=0.
REQ-029 SHALL increment stall_count by 1 on each edge where REQ-027 applied; saturate at 2^CW-1.
REQ-030 SHALL, with LOAD_LAT=1 and mem_stall=ex_flush=0, produce exactly one stall cycle per dependent load (classic load-use).
REQ-031 SHALL, with LOAD_LAT=N, stall a dependent instruction immediately behind a load for N cycles; at distance d (1<=d<=N), N-d+1 cycles.

Reset
REQ-032 SHALL, while reset=0, clear all pending entries to valid=0 and stall_count to 0, asynchronously.
REQ-033 SHALL drive outputs per REQ-028 in and right after reset (no pending loads).
REQ-034 SHALL discard pending entries on reset mid-stall; first cycle after release shows no hazard unless EX inputs match.

Structure
REQ-035 SHALL place NOP/bubble encoding constants and the LOAD_LAT legal range in the shared pipeline package.
REQ-036 SHALL use one sub-module, load_scoreboard, holding the pending pipe and returning the per-source match vector.

Verification
REQ-037 LOAD_LAT=1: ex_mem_read=1, ex_rd=5, id_rs={5,0}, used=2'b01 -> one cycle pc_write=0, hazard_out=1; next cycle all enables 1; stall_count=1.
REQ-038 LOAD_LAT=3: load x7 then immediately dependent instruction on rs2=7 -> 3 consecutive stall cycles, stall_count=3.
REQ-039 ex_rd=0 load, id_rs={0,0} used=2'b11 -> no stall; ex_rd=9 load, rs=9 used=0 -> no stall.
REQ-040 load-use match plus ex_flush=1 same cycle -> if_id_flush=1, pc_write=1, stall_count unchanged.
REQ-041 LOAD_LAT=2, pending x3, mem_stall=1 for 4 cycles -> all enables 0, pending held; after release exactly one remaining stall cycle for rs=3.
REQ-042 CW=4, 20 load-use stalls -> stall_count=15; reset=0 mid-stall -> stall_count=0, no hazard after release.
